// File: rtl/eth_sched_pkg.sv
// Shared types and constants for the egress frame scheduler and its round-robin arbiter.
package eth_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        XMIT,
        GAP
    } sched_state_t;

    localparam int unsigned IFG_DEFAULT          = 12;
    localparam int unsigned PAUSE_QUANTUM_CYCLES = 64;
    localparam int unsigned ETH_MAX_LEN          = 1530;
    localparam int unsigned PAUSE_CNT_W          = 22;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping to 0.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          any
);

    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PW'((32'(ptr) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/egress_frame_scheduler.sv
// Per-port egress scheduler: frame-granular round-robin onto one GMII byte transmitter.
// Optional MAC Control PAUSE support is compiled in when PAUSE_EN is defined.
module egress_frame_scheduler
    import eth_sched_pkg::*;
#(
    parameter int unsigned N_PORTS    = 4,
    parameter int unsigned IFG_CYCLES = IFG_DEFAULT,
    parameter int unsigned MAX_LEN    = ETH_MAX_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_PORTS-1:0]   q_req,
    input  logic [N_PORTS*8-1:0] q_data,
    input  logic [N_PORTS-1:0]   q_last,
    output logic [N_PORTS-1:0]   q_rd,
    output logic [N_PORTS-1:0]   q_drop,
    output logic [N_PORTS-1:0]   grant,
    output logic                 tx_dv,
    output logic                 tx_er,
    output logic [7:0]           tx_data,
    input  logic                 pause_valid,
    input  logic [15:0]          pause_quanta,
    output logic                 paused,
    output logic [15:0]          tx_frames
);

    localparam int unsigned PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int unsigned CW = $clog2(MAX_LEN + 1);
    localparam int unsigned GW = $clog2(IFG_CYCLES + 1);

    sched_state_t         state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [N_PORTS-1:0]   grant_q, grant_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic                 tx_dv_q, tx_dv_d;
    logic                 tx_er_q, tx_er_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [15:0]          tx_frames_q, tx_frames_d;

    logic [N_PORTS-1:0]   arb_gnt;
    logic                 arb_any;
    logic [PW-1:0]        win_idx;
    logic [PW-1:0]        next_ptr;
    logic                 sel_req;
    logic                 sel_last;
    logic [7:0]           sel_data;

    rr_arbiter #(
        .N  (N_PORTS),
        .PW (PW)
    ) u_rr_arbiter (
        .req (q_req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .any (arb_any)
    );

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (arb_gnt[i]) win_idx = PW'(i);
        end
    end

    assign next_ptr = (win_idx == PW'(N_PORTS - 1)) ? '0 : win_idx + 1'b1;

    // Head of the granted queue; grant_q is one-hot or zero.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (grant_q[i]) sel_data = sel_data | q_data[i*8 +: 8];
        end
    end

    assign sel_req  = |(q_req & grant_q);
    assign sel_last = |(q_last & grant_q);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        tx_frames_d = tx_frames_q;
        tx_dv_d     = 1'b0;
        tx_er_d     = 1'b0;
        tx_data_d   = '0;
        q_rd        = '0;
        q_drop      = '0;
        unique case (state_q)
            IDLE: begin
                if (arb_any && !paused) begin
                    state_d = GRANT;
                    grant_d = arb_gnt;
                    ptr_d   = next_ptr;
                end
            end
            GRANT: begin
                state_d = XMIT;
                cnt_d   = '0;
            end
            XMIT: begin
                // Underrun or a frame reaching MAX_LEN bytes without its FCS end is aborted.
                if (!sel_req || (!sel_last && cnt_q == CW'(MAX_LEN - 1))) begin
                    tx_dv_d   = 1'b1;
                    tx_er_d   = 1'b1;
                    tx_data_d = sel_data;
                    q_drop    = grant_q;
                    grant_d   = '0;
                    gap_d     = '0;
                    state_d   = GAP;
                end else begin
                    q_rd      = grant_q;
                    tx_dv_d   = 1'b1;
                    tx_data_d = sel_data;
                    cnt_d     = cnt_q + 1'b1;
                    if (sel_last) begin
                        tx_frames_d = tx_frames_q + 16'd1;
                        grant_d     = '0;
                        gap_d       = '0;
                        state_d     = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == GW'(IFG_CYCLES - 1)) state_d = IDLE;
                else                              gap_d   = gap_q + 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            tx_dv_q     <= 1'b0;
            tx_er_q     <= 1'b0;
            tx_data_q   <= '0;
            tx_frames_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            tx_dv_q     <= tx_dv_d;
            tx_er_q     <= tx_er_d;
            tx_data_q   <= tx_data_d;
            tx_frames_q <= tx_frames_d;
        end
    end

`ifdef PAUSE_EN
    logic [PAUSE_CNT_W-1:0] pause_cnt_q, pause_cnt_d;

    always_comb begin
        pause_cnt_d = pause_cnt_q;
        if (pause_valid) begin
            pause_cnt_d = PAUSE_CNT_W'(pause_quanta) * PAUSE_CNT_W'(PAUSE_QUANTUM_CYCLES);
        end else if (pause_cnt_q != '0) begin
            pause_cnt_d = pause_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pause_cnt_q <= '0;
        else     pause_cnt_q <= pause_cnt_d;
    end

    assign paused = (pause_cnt_q != '0);
`else
    logic unused_pause;
    assign unused_pause = ^{pause_valid, pause_quanta};
    assign paused       = 1'b0;
`endif

    assign grant     = grant_q;
    assign tx_dv     = tx_dv_q;
    assign tx_er     = tx_er_q;
    assign tx_data   = tx_data_q;
    assign tx_frames = tx_frames_q;

endmodule

// File: tb/tb_egress_frame_scheduler.sv
// Directed bench for egress_frame_scheduler: byte-queue sources, a rule-based per-cycle
// monitor (pops echo on tx one cycle later, round-robin winner, frame count) and literal checks.
module tb_egress_frame_scheduler;

    localparam int N    = 4;
    localparam int IFG  = 12;
    localparam int MAXL = 1530;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   q_req, q_last, q_rd, q_drop, grant;
    logic [N*8-1:0] q_data;
    logic           tx_dv, tx_er, paused, pause_valid;
    logic [7:0]     tx_data;
    logic [15:0]    pause_quanta, tx_frames;

    always #5 clk = ~clk;

    egress_frame_scheduler #(
        .N_PORTS    (N),
        .IFG_CYCLES (IFG),
        .MAX_LEN    (MAXL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .q_req        (q_req),
        .q_data       (q_data),
        .q_last       (q_last),
        .q_rd         (q_rd),
        .q_drop       (q_drop),
        .grant        (grant),
        .tx_dv        (tx_dv),
        .tx_er        (tx_er),
        .tx_data      (tx_data),
        .pause_valid  (pause_valid),
        .pause_quanta (pause_quanta),
        .paused       (paused),
        .tx_frames    (tx_frames)
    );

    int checks = 0;
    int failures = 0;

    logic [8:0] src [N][$];  // {last, byte} per queue
    logic [N-1:0] req_en;

    int cyc = 0;
    logic       exp_dv, exp_er;
    logic [7:0] exp_data;
    int         exp_frames, model_ptr, w, idx;
    logic [N-1:0] prev_req, prev_grant, prev_rd, rd_s, drop_s;
    int grant_log[$];
    int gap_log[$];
    int dv_cnt, er_cnt, er_pos, paused_cnt, last_dv_cyc, grant_cyc, first_rd_cyc;
    int pop_cnt[N];
    int drop_cnt[N];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int glog(input int i);
        return (i < grant_log.size()) ? grant_log[i] : -1;
    endfunction

    function automatic int gaplog(input int i);
        return (i < gap_log.size()) ? gap_log[i] : -1;
    endfunction

    // Monitor and reference model, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_dv = 1'b0; exp_er = 1'b0; exp_data = '0;
            exp_frames = 0; model_ptr = 0;
            prev_req = '0; prev_grant = '0; prev_rd = '0; rd_s = '0; drop_s = '0;
        end else begin
            if (exp_er) check("tx_error_byte", {tx_dv, tx_er}, 2'b11);
            else        check("tx_bus", {tx_dv, tx_er, tx_data}, {exp_dv, exp_er, exp_data});
            check("tx_frames", tx_frames, exp_frames);
`ifndef PAUSE_EN
            check("paused_tied_low", paused, 0);
`endif
            if (q_rd != '0) begin
                check("q_rd_owner", q_rd, grant);
                check("q_rd_without_req", q_rd & ~q_req, 0);
            end
            if (q_drop != '0) check("q_drop_owner", q_drop, grant);
            if (grant != '0 && prev_grant == '0) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (model_ptr + k) % N;
                    if (w < 0 && prev_req[idx]) w = idx;
                end
                check("rr_winner", grant, (w < 0) ? 0 : (1 << w));
                for (int k = 0; k < N; k++) if (grant[k]) grant_log.push_back(k);
                if (w >= 0) model_ptr = (w + 1) % N;
                grant_cyc = cyc;
            end
            if (q_rd != '0 && prev_rd == '0) begin
                if (last_dv_cyc >= 0) gap_log.push_back(cyc - last_dv_cyc);
                first_rd_cyc = cyc;
            end
            if (tx_dv) begin dv_cnt++; last_dv_cyc = cyc; end
            if (tx_er) begin er_cnt++; er_pos = dv_cnt; end
            if (paused) paused_cnt++;
            exp_dv = 1'b0; exp_er = 1'b0; exp_data = '0;
            for (int p = 0; p < N; p++) begin
                if (q_rd[p]) begin
                    exp_dv = 1'b1;
                    exp_data = q_data[p*8 +: 8];
                    pop_cnt[p]++;
                    if (q_last[p]) exp_frames = (exp_frames + 1) % 65536;
                end
                if (q_drop[p]) begin
                    exp_dv = 1'b1; exp_er = 1'b1;
                    drop_cnt[p]++;
                end
            end
            prev_req = q_req; prev_grant = grant; prev_rd = q_rd;
            rd_s = q_rd; drop_s = q_drop;
        end
    end

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            logic [8:0] v;
            v = (src[p].size() > 0) ? src[p][0] : 9'h0;
            q_req[p] = req_en[p] && (src[p].size() > 0);
            q_data[p*8 +: 8] = v[7:0];
            q_last[p] = v[8] & q_req[p];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            if (rd_s[p] && src[p].size() > 0) void'(src[p].pop_front());
            if (drop_s[p]) begin
                while (src[p].size() > 0) begin
                    logic [8:0] v;
                    v = src[p].pop_front();
                    if (v[8]) break;
                end
            end
        end
        drive();
    endtask

    task automatic load(input int p, input int len, input bit with_last, input int seed);
        for (int i = 0; i < len; i++) begin
            logic [7:0] b;
            if (i < 7)       b = 8'h55;
            else if (i == 7) b = 8'hD5;
            else             b = 8'((i * 13 + seed * 29 + p) & 255);
            src[p].push_back({(with_last && i == len - 1), b});
        end
        drive();
    endtask

    task automatic clear_stats();
        dv_cnt = 0; er_cnt = 0; er_pos = 0; paused_cnt = 0;
        last_dv_cyc = -1; grant_cyc = 0; first_rd_cyc = 0;
        grant_log.delete(); gap_log.delete();
        for (int p = 0; p < N; p++) begin pop_cnt[p] = 0; drop_cnt[p] = 0; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int p = 0; p < N; p++) src[p].delete();
        req_en = '1;
        drive();
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        bit busy;
        do begin
            step();
            n++;
            busy = (grant != '0) || tx_dv;
            for (int p = 0; p < N; p++) if (req_en[p] && src[p].size() != 0) busy = 1'b1;
        end while (busy && n < budget);
        check({name, "_timeout"}, busy, 0);
        repeat (IFG + 4) step();
    endtask

    task automatic wait_pops(input int p, input int n, input string name);
        int k = 0;
        while (pop_cnt[p] < n && k < 5000) begin step(); k++; end
        check({name, "_pops"}, pop_cnt[p], n);
    endtask

    initial begin
        int req_cyc, p_cyc, r_cyc;
        int exp_order[6] = '{0, 2, 3, 0, 2, 3};
        rst = 1'b1; pause_valid = 1'b0; pause_quanta = '0; req_en = '1;
        q_req = '0; q_data = '0; q_last = '0;
        clear_stats();
        drive();
        repeat (3) step();
        check("reset_outputs", {q_rd, q_drop, grant, tx_dv, tx_er, tx_data, paused, tx_frames}, 0);
        rst = 1'b0;
        step();

        // Single 72-byte frame on queue 0: latency, length and count.
        clear_stats();
        load(0, 72, 1, 1);
        req_cyc = cyc + 1;
        wait_idle(300, "t1");
        check("t1_grant_latency", grant_cyc - req_cyc, 1);
        check("t1_first_pop_latency", first_rd_cyc - req_cyc, 2);
        check("t1_dv_cycles", dv_cnt, 72);
        check("t1_err_cycles", er_cnt, 0);
        check("t1_tx_frames", tx_frames, 1);

        // Queues 0, 2, 3 with two frames each: rotation and inter-frame spacing.
        do_reset();
        clear_stats();
        load(0, 20, 1, 2); load(0, 24, 1, 3);
        load(2, 30, 1, 4); load(2, 18, 1, 5);
        load(3, 25, 1, 6); load(3, 16, 1, 7);
        wait_idle(1000, "t2");
        check("t2_grant_count", grant_log.size(), 6);
        for (int i = 0; i < 6; i++) check("t2_grant_order", glog(i), exp_order[i]);
        check("t2_gap_count", gap_log.size(), 5);
        for (int i = 0; i < 5; i++) check("t2_gap_last_dv_to_pop", gaplog(i), IFG + 2);
        check("t2_tx_frames", tx_frames, 6);

        // Underrun on queue 1 after 30 of 100 bytes; queue 3 waits behind it.
        clear_stats();
        load(1, 100, 1, 8);
        wait_pops(1, 30, "t3");
        req_en[1] = 1'b0;
        drive();
        load(3, 16, 1, 9);
        wait_idle(600, "t3");
        req_en[1] = 1'b1;
        check("t3_err_cycles", er_cnt, 1);
        check("t3_drop_pulses", drop_cnt[1], 1);
        check("t3_pops_q1", pop_cnt[1], 30);
        check("t3_dv_cycles", dv_cnt, 31 + 16);
        check("t3_tx_frames", tx_frames, 7);
        check("t3_gap_after_error", gaplog(0), IFG + 2);
        check("t3_order_first", glog(0), 1);
        check("t3_order_second", glog(1), 3);

        // 1600 bytes with no end on queue 2: aborted on byte 1530.
        clear_stats();
        load(2, 1600, 0, 10);
        while (grant_log.size() == 0 && cyc < 100000) step();
        load(0, 20, 1, 11);
        wait_idle(4000, "t4");
        check("t4_err_cycles", er_cnt, 1);
        check("t4_err_position", er_pos, MAXL);
        check("t4_pops_q2", pop_cnt[2], MAXL - 1);
        check("t4_drop_pulses", drop_cnt[2], 1);
        check("t4_dv_cycles", dv_cnt, MAXL + 20);
        check("t4_tx_frames", tx_frames, 8);
        check("t4_gap_after_error", gaplog(0), IFG + 2);
        check("t4_next_grant", glog(1), 0);

        // Reset mid-frame, then pointer restarts at 0.
        clear_stats();
        load(2, 40, 1, 12);
        wait_pops(2, 10, "t5");
        rst = 1'b1;
        #1;
        check("t5_async_reset_outputs",
              {q_rd, q_drop, grant, tx_dv, tx_er, tx_data, paused, tx_frames}, 0);
        for (int p = 0; p < N; p++) src[p].delete();
        drive();
        step(); step();
        rst = 1'b0;
        step();
        clear_stats();
        load(1, 12, 1, 13);
        load(3, 12, 1, 14);
        wait_idle(300, "t5");
        check("t5_first_winner", glog(0), 1);
        check("t5_second_winner", glog(1), 3);
        check("t5_tx_frames", tx_frames, 2);

`ifdef PAUSE_EN
        // Pause of 3 quanta mid-frame: frame completes, next grant held off 192 cycles.
        do_reset();
        clear_stats();
        load(0, 40, 1, 15);
        wait_pops(0, 10, "t6");
        pause_valid = 1'b1; pause_quanta = 16'd3;
        load(1, 20, 1, 16);
        p_cyc = cyc + 1;
        step();
        pause_valid = 1'b0;
        while (grant_log.size() < 2 && cyc < p_cyc + 400) step();
        check("t6_grant_after_pause", grant_cyc - p_cyc, 194);
        wait_idle(400, "t6");
        check("t6_paused_cycles", paused_cnt, 192);
        check("t6_tx_frames", tx_frames, 2);
        check("t6_second_winner", glog(1), 1);

        // Quanta 0 releases an active pause at once.
        pause_valid = 1'b1; pause_quanta = 16'd3;
        step();
        pause_valid = 1'b0;
        repeat (20) step();
        load(3, 10, 1, 17);
        repeat (20) step();
        check("t6_held_paused", paused, 1);
        check("t6_no_grant_while_paused", grant_log.size(), 2);
        pause_valid = 1'b1; pause_quanta = 16'd0;
        r_cyc = cyc + 1;
        step();
        pause_valid = 1'b0;
        repeat (3) step();
        check("t6_resume_grant_latency", grant_cyc - r_cyc, 2);
        wait_idle(300, "t6b");
        check("t6_tx_frames_final", tx_frames, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
